// File: rtl/mem_arb_ctrl_pkg.sv
// Shared constants for the arbitrated word memory: default geometry and the
// width of a port index, sized for the largest supported port count.
package mem_arb_ctrl_pkg;

    localparam int WORD      = 32;
    localparam int ADDR      = 16;
    localparam int BYTES     = WORD / 8;
    localparam int NPORT_MAX = 8;
    localparam int PIDX      = $clog2(NPORT_MAX);

endpackage

// File: rtl/mem_arb_ctrl_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on a read access, so it holds between reads.
module mem_arb_ctrl_mem_array #(
    parameter int WORD = mem_arb_ctrl_pkg::WORD,
    parameter int ADDR = mem_arb_ctrl_pkg::ADDR
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR-1:0]       addr,
    input  logic [WORD/8-1:0]     be,
    input  logic [WORD-1:0]       wdata,
    output logic [WORD-1:0]       rdata
);

    localparam int NBYTE = WORD / 8;
    localparam int DEPTH = 2 ** ADDR;

    logic [WORD-1:0] storage [DEPTH];
    logic [WORD-1:0] rdata_reg;

    // Byte-masked write or registered read; storage is never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < NBYTE; b++) begin
                    if (be[b]) begin
                        storage[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata_reg <= storage[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter putting NPORT requesters onto one word RAM, with an
// RD_LAT-deep response pipeline returning one pulse per accepted request.
module mem_arb_ctrl #(
    parameter int WORD   = mem_arb_ctrl_pkg::WORD,
    parameter int ADDR   = mem_arb_ctrl_pkg::ADDR,
    parameter int NPORT  = 2,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPORT-1:0]          req_valid,
    output logic [NPORT-1:0]          req_ready,
    input  logic [NPORT-1:0]          req_write,
    input  logic [NPORT*ADDR-1:0]     req_addr,
    input  logic [NPORT*(WORD/8)-1:0] req_be,
    input  logic [NPORT*WORD-1:0]     req_wdata,
    output logic [NPORT-1:0]          rsp_valid,
    output logic [WORD-1:0]           rsp_rdata
);

    import mem_arb_ctrl_pkg::*;

    localparam int NBYTE = WORD / 8;

    logic [PIDX-1:0]  ptr_reg;
    logic             hi_any, lo_any;
    logic [PIDX-1:0]  hi_idx, lo_idx;
    logic             grant_any;
    logic [PIDX-1:0]  grant_idx;
    logic             sel_write;
    logic [ADDR-1:0]  sel_addr;
    logic [NBYTE-1:0] sel_be;
    logic [WORD-1:0]  sel_wdata;
    logic [WORD-1:0]  mem_rdata;
    logic [WORD-1:0]  hold_reg;

    // Pick the first requester strictly above the pointer, else the first one at or below it.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (req_valid[i]) begin
                if (PIDX'(i) > ptr_reg) begin
                    if (!hi_any) begin
                        hi_any = 1'b1;
                        hi_idx = PIDX'(i);
                    end
                end else if (!lo_any) begin
                    lo_any = 1'b1;
                    lo_idx = PIDX'(i);
                end
            end
        end
        grant_any = reset && (hi_any || lo_any);
        grant_idx = hi_any ? hi_idx : lo_idx;
    end

    // One-hot grant and steering of the granted port's request fields.
    always_comb begin
        req_ready = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_idx == PIDX'(i)) begin
                req_ready[i] = grant_any;
                sel_write    = req_write[i];
                sel_addr     = req_addr[i*ADDR +: ADDR];
                sel_be       = req_be[i*NBYTE +: NBYTE];
                sel_wdata    = req_wdata[i*WORD +: WORD];
            end
        end
    end

    // Pointer remembers the last accepted port; reset value gives port 0 first turn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_reg <= PIDX'(NPORT - 1);
        end else if (grant_any) begin
            ptr_reg <= grant_idx;
        end
    end

    mem_arb_ctrl_mem_array #(
        .WORD (WORD),
        .ADDR (ADDR)
    ) u_mem (
        .clk   (clk),
        .en    (grant_any),
        .we    (sel_write),
        .addr  (sel_addr),
        .be    (sel_be),
        .wdata (sel_wdata),
        .rdata (mem_rdata)
    );

    // Stage 0 lines up with the RAM read register; later stages add latency.
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic            v_reg;
        logic [PIDX-1:0] port_reg;
        logic            write_reg;
        logic [WORD-1:0] data;

        if (gi == 0) begin : g_head
            // Capture the accepted request's tag on the acceptance edge.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v_reg     <= 1'b0;
                    port_reg  <= '0;
                    write_reg <= 1'b0;
                end else begin
                    v_reg     <= grant_any;
                    port_reg  <= grant_idx;
                    write_reg <= sel_write;
                end
            end
            assign data = mem_rdata;
        end else begin : g_tail
            logic [WORD-1:0] data_reg;

            // Shift the tag one stage; reset drops anything in flight.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v_reg     <= 1'b0;
                    port_reg  <= '0;
                    write_reg <= 1'b0;
                end else begin
                    v_reg     <= g_stage[gi-1].v_reg;
                    port_reg  <= g_stage[gi-1].port_reg;
                    write_reg <= g_stage[gi-1].write_reg;
                end
            end

            // Read data follows its tag; qualified by v_reg so no reset needed.
            always_ff @(posedge clk) begin
                data_reg <= g_stage[gi-1].data;
            end
            assign data = data_reg;
        end
    end

    logic            fin_valid;
    logic [PIDX-1:0] fin_port;
    logic            fin_write;
    logic [WORD-1:0] fin_data;

    assign fin_valid = g_stage[RD_LAT-1].v_reg;
    assign fin_port  = g_stage[RD_LAT-1].port_reg;
    assign fin_write = g_stage[RD_LAT-1].write_reg;
    assign fin_data  = g_stage[RD_LAT-1].data;

    // Response pulse on the owning port, data zero for writes, held otherwise.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NPORT; i++) begin
            rsp_valid[i] = fin_valid && (fin_port == PIDX'(i));
        end
        rsp_rdata = hold_reg;
        if (fin_valid) begin
            rsp_rdata = fin_write ? '0 : fin_data;
        end
    end

    // Remember the last presented response word so rsp_rdata holds between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg <= '0;
        end else if (fin_valid) begin
            hold_reg <= rsp_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench: two instances (RD_LAT=1 and RD_LAT=3) share the same
// request stimulus; a memory/arbiter model predicts grants and responses.
module tb_mem_arb_ctrl;

    localparam int NP = 2;
    localparam int W  = 32;
    localparam int A  = 16;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [NP-1:0]   req_valid = '0;
    logic [NP-1:0]   req_write = '0;
    logic [NP*A-1:0] req_addr  = '0;
    logic [NP*4-1:0] req_be    = '0;
    logic [NP*W-1:0] req_wdata = '0;
    logic [NP-1:0]   ready1, ready3, rv1, rv3;
    logic [W-1:0]    rd1, rd3;

    always #5 clk = ~clk;

    mem_arb_ctrl #(.WORD(W), .ADDR(A), .NPORT(NP), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_rdata(rd1));

    mem_arb_ctrl #(.WORD(W), .ADDR(A), .NPORT(NP), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
        .req_write(req_write), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_rdata(rd3));

    typedef struct packed {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] mem_m [int];
    int          checks = 0;
    int          errors = 0;
    int          cnt = 0;
    int          m_ptr = NP - 1;
    int          model_grant = -1;
    int          txn = 0;
    logic [31:0] last1 = '0;
    logic [31:0] last3 = '0;

    always @(posedge clk) cnt++;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cnt, act, expv);
        end
    endtask

    function automatic bit pv(input int idx);
        bit r;
        r = 1'b0;
        for (int k = 0; k < NP; k++) if (k == idx) r = req_valid[k];
        return r;
    endfunction

    // Reset flushes everything the model expects and restores the pointer.
    always @(negedge reset) begin
        q1.delete();
        q3.delete();
        last1 = '0;
        last3 = '0;
        m_ptr = NP - 1;
        model_grant = -1;
    end

    // Reference model: round-robin grant from the last winner, byte-masked memory.
    always @(negedge clk) begin
        int          g;
        int          a;
        logic [31:0] wd, word, rdv;
        logic [3:0]  be;
        logic [NP-1:0] er;
        bit          w;
        g = -1;
        if (reset) begin
            for (int i = 1; i <= NP; i++) begin
                if (g < 0 && pv((m_ptr + i) % NP)) g = (m_ptr + i) % NP;
            end
        end
        er = (g >= 0) ? NP'(1 << g) : '0;
        cmp("ready_lat1", 32'(ready1), 32'(er));
        cmp("ready_lat3", 32'(ready3), 32'(er));
        if (g >= 0) begin
            w  = req_write[g];
            a  = int'(req_addr[g*A +: A]);
            be = req_be[g*4 +: 4];
            wd = req_wdata[g*W +: W];
            word = mem_m.exists(a) ? mem_m[a] : 32'h0;
            if (w) begin
                for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = wd[b*8 +: 8];
                mem_m[a] = word;
                rdv = 32'h0;
            end else begin
                rdv = word;
            end
            q1.push_back('{port: g, data: rdv, due: cnt + 1});
            q3.push_back('{port: g, data: rdv, due: cnt + 3});
            m_ptr = g;
            txn++;
            $display("txn %0d cyc=%0d port=%0d %s addr=%h be=%h wdata=%h exp_rdata=%h",
                     txn, cnt, g, w ? "WR" : "RD", a[15:0], be, wd, rdv);
        end
        model_grant = g;
    end

    task automatic mon(input string nm, input logic [NP-1:0] v, input logic [31:0] d,
                       input int qs, input exp_t h, input logic [31:0] last, output bit pop);
        pop = 1'b0;
        if (!reset) begin
            cmp({nm, "_rst_valid"}, 32'(v), 32'h0);
            cmp({nm, "_rst_rdata"}, d, 32'h0);
        end else if (qs > 0 && h.due <= cnt) begin
            pop = 1'b1;
            cmp({nm, "_rsp_valid"}, 32'(v), 32'(1 << h.port));
            cmp({nm, "_rsp_rdata"}, d, h.data);
        end else begin
            cmp({nm, "_idle_valid"}, 32'(v), 32'h0);
            cmp({nm, "_hold_rdata"}, d, last);
        end
    endtask

    // Monitor: compare each instance's outputs against the head of its queue.
    always @(negedge clk) begin
        exp_t h;
        bit   pop;
        h = '0;
        if (q1.size() > 0) h = q1[0];
        mon("lat1", rv1, rd1, q1.size(), h, last1, pop);
        if (pop) begin
            last1 = h.data;
            void'(q1.pop_front());
        end
        h = '0;
        if (q3.size() > 0) h = q3[0];
        mon("lat3", rv3, rd3, q3.size(), h, last3, pop);
        if (pop) begin
            last3 = h.data;
            void'(q3.pop_front());
        end
    end

    task automatic put(input int p, input bit w, input int a, input logic [3:0] be,
                       input logic [31:0] d);
        req_valid[p]        = 1'b1;
        req_write[p]        = w;
        req_addr[p*A +: A]  = A'(a);
        req_be[p*4 +: 4]    = be;
        req_wdata[p*W +: W] = d;
    endtask

    // Wait (bounded) for the model to see port p accepted, then drop its valid.
    task automatic wait_grant(input int p);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (model_grant != p && n < 50);
        checks++;
        if (model_grant != p) begin
            errors++;
            $display("FAIL grant_timeout port=%0d act=%0d exp=%0d", p, model_grant, p);
        end
        req_valid[p] = 1'b0;
    endtask

    task automatic xfer(input int p, input bit w, input int a, input logic [3:0] be,
                        input logic [31:0] d);
        put(p, w, a, be, d);
        wait_grant(p);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (req_valid != '0 && n < 50) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) if (model_grant == p) req_valid[p] = 1'b0;
            n++;
        end
        checks++;
        if (req_valid != '0) begin
            errors++;
            $display("FAIL drain_timeout act=%b exp=00", req_valid);
        end
    endtask

    initial begin
        // Reset with both ports requesting: nothing may be granted or returned.
        #2 reset = 1'b0;
        put(0, 1'b1, 62, 4'hF, 32'h0BAD_F00D);
        put(1, 1'b1, 63, 4'hF, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drain();

        // Initialise every address the rest of the run touches.
        for (int a = 0; a < 62; a++) xfer(0, 1'b1, a, 4'hF, $urandom);

        // Write then read back-to-back on port 0.
        xfer(0, 1'b1, 'h10, 4'hF, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 'h10, 4'h0, 32'h0);

        // Byte enables, including an all-zero mask that must still complete.
        xfer(0, 1'b1, 'h20, 4'hF, 32'h1122_3344);
        xfer(0, 1'b1, 'h20, 4'b0101, 32'hAABB_CCDD);
        xfer(0, 1'b0, 'h20, 4'h0, 32'h0);
        xfer(1, 1'b1, 'h20, 4'h0, 32'hFFFF_FFFF);
        xfer(1, 1'b0, 'h20, 4'h0, 32'h0);

        // Both ports continuously valid for 6 cycles: grants must alternate.
        put(0, 1'b0, 1, 4'h0, 32'h0);
        put(1, 1'b0, 2, 4'h0, 32'h0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        req_valid = '0;

        // Isolated read so the RD_LAT=3 pulse stands alone.
        repeat (4) @(posedge clk);
        #1;
        xfer(1, 1'b0, 'h10, 4'h0, 32'h0);
        repeat (5) @(posedge clk);
        #1;

        // Random traffic; requests stay stable until granted.
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < NP; p++) if (model_grant == p) req_valid[p] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!req_valid[p] && $urandom_range(0, 2) != 0)
                    put(p, 1'($urandom_range(0, 1)), $urandom_range(0, 63),
                        4'($urandom), $urandom);
            end
            @(posedge clk);
            #1;
        end
        for (int p = 0; p < NP; p++) if (model_grant == p) req_valid[p] = 1'b0;
        drain();

        // Reset with two reads in flight: they vanish, memory survives.
        repeat (4) @(posedge clk);
        #1;
        xfer(0, 1'b0, 'h10, 4'h0, 32'h0);
        xfer(1, 1'b0, 'h20, 4'h0, 32'h0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        xfer(0, 1'b0, 'h10, 4'h0, 32'h0);
        xfer(1, 1'b0, 'h20, 4'h0, 32'h0);
        xfer(0, 1'b0, 62, 4'h0, 32'h0);

        repeat (8) @(posedge clk);
        #1;
        cmp("lat1_queue_empty", 32'(q1.size()), 32'h0);
        cmp("lat3_queue_empty", 32'(q3.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
